// File: rtl/float_pkg.sv
// Shared constants, field widths, FSM state type and small helpers for the
// float accumulator datapath.
package float_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    // Working mantissa: guard/carry bit, hidden one, fraction.
    localparam int MANT_W = FRAC_W + 2;

    localparam int                EXP_BIAS   = 127;
    localparam logic [EXP_W-1:0]  EXP_INF    = 8'hFF;
    localparam logic [30:0]       MAX_FINITE = 31'h7F7FFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_ADD   = 3'd3,
        ST_NORM  = 3'd4,
        ST_DONE  = 3'd5
    } acc_state_e;

    // A zero exponent field means the value is zero, whatever the fraction.
    function automatic logic is_zero(input logic [31:0] f);
        return (f[30:23] == '0);
    endfunction

    // Expand to {carry, hidden one, fraction}; zero values expand to 0.
    function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] f);
        return is_zero(f) ? '0 : {2'b01, f[22:0]};
    endfunction

endpackage

// File: rtl/float_align_shift.sv
// Combinational 25-bit logarithmic right shifter; shift amounts of 25 or
// more clear the result so far-smaller operands vanish entirely.
module float_align_shift
    import float_pkg::*;
(
    input  logic [MANT_W-1:0] din_i,
    input  logic [7:0]        shamt_i,
    output logic [MANT_W-1:0] dout_o
);

    logic [5:0][MANT_W-1:0] stage;

    assign stage[0] = din_i;

    // Stage gi conditionally shifts by 2**gi.
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
        assign stage[gi+1] = shamt_i[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
    end

    assign dout_o = (shamt_i >= 8'd25) ? '0 : stage[5];

endmodule

// File: rtl/float_accumulator.sv
// Sequential single-precision accumulator: sums N products over a
// valid/ready stream with a multi-cycle align/add/normalize datapath.
module float_accumulator
    import float_pkg::*;
#(
    parameter int N = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);

    acc_state_e         state_q, state_d;
    logic [31:0]        acc_q, acc_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [MANT_W-1:0]  ma_q, ma_d, mb_q, mb_d, mant_q, mant_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_q, sign_d;

    // Alignment: route the smaller-exponent mantissa through the shifter.
    logic [EXP_W-1:0]   a_exp, b_exp, sh_amt;
    logic [MANT_W-1:0]  a_man, b_man, sh_in, sh_out;
    logic               a_ge;

    assign a_exp  = acc_q[30:23];
    assign b_exp  = b_q[30:23];
    assign a_man  = unpack_mant(acc_q);
    assign b_man  = unpack_mant(b_q);
    assign a_ge   = (a_exp >= b_exp);
    assign sh_in  = a_ge ? b_man : a_man;
    assign sh_amt = a_ge ? (a_exp - b_exp) : (b_exp - a_exp);

    float_align_shift u_shift (
        .din_i   (sh_in),
        .shamt_i (sh_amt),
        .dout_o  (sh_out)
    );

    assign cnt_inc = cnt_q + CW'(1);

    // Normalizer decision for the current NORM cycle: one shift or a finish.
    logic               norm_fin;
    logic [31:0]        norm_res;
    logic [MANT_W-1:0]  norm_mant;
    logic [EXP_W-1:0]   norm_exp;

    always_comb begin
        norm_fin  = 1'b0;
        norm_res  = '0;
        norm_mant = mant_q;
        norm_exp  = exp_q;
        if (mant_q == '0) begin
            norm_fin = 1'b1;
        end else if (mant_q[24]) begin
            if (exp_q == EXP_INF - 8'd1) begin
                norm_fin = 1'b1;
                norm_res = {sign_q, MAX_FINITE};
            end else begin
                norm_mant = mant_q >> 1;
                norm_exp  = exp_q + 8'd1;
            end
        end else if (!mant_q[23]) begin
            if (exp_q == 8'd1) begin
                norm_fin = 1'b1;
            end else begin
                norm_mant = mant_q << 1;
                norm_exp  = exp_q - 8'd1;
            end
        end else begin
            norm_fin = 1'b1;
            norm_res = {sign_q, exp_q, mant_q[22:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_WAIT;
            ST_WAIT:  if (in_valid) state_d = ST_ALIGN;
            ST_ALIGN: state_d = is_zero(b_q) ? ST_NORM : ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  if (norm_fin) state_d = (cnt_inc == N_C) ? ST_DONE : ST_WAIT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only.
    always_comb begin
        in_ready = (state_q == ST_WAIT);
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
    end

    assign sum = sum_q;

    // Datapath next-state values per FSM state.
    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sign_d   = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (in_valid) b_d = in_data;
            end
            ST_ALIGN: begin
                if (is_zero(b_q)) begin
                    mant_d = a_man;
                    exp_d  = a_exp;
                    sign_d = is_zero(acc_q) ? 1'b0 : acc_q[31];
                end else begin
                    ma_d     = a_ge ? a_man : sh_out;
                    mb_d     = a_ge ? sh_out : b_man;
                    exp_d    = a_ge ? a_exp : b_exp;
                    sign_a_d = acc_q[31];
                    sign_b_d = b_q[31];
                end
            end
            ST_ADD: begin
                if (sign_a_q == sign_b_q) begin
                    mant_d = ma_q + mb_q;
                    sign_d = sign_a_q;
                end else if (ma_q > mb_q) begin
                    mant_d = ma_q - mb_q;
                    sign_d = sign_a_q;
                end else if (mb_q > ma_q) begin
                    mant_d = mb_q - ma_q;
                    sign_d = sign_b_q;
                end else begin
                    mant_d = '0;
                    sign_d = 1'b0;
                end
            end
            ST_NORM: begin
                mant_d = norm_mant;
                exp_d  = norm_exp;
                if (norm_fin) begin
                    acc_d = norm_res;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_C) sum_d = norm_res;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sign_q   <= sign_d;
        end
    end

endmodule

// File: tb/tb_float_accumulator.sv
// Directed bench for float_accumulator: four instances with N = 1..4 share
// one clock; each scenario drives the instance whose N it needs.
module tb_float_accumulator;

    logic        clk = 1'b0;
    logic        rst_s   [4];
    logic        start_s [4];
    logic        valid_s [4];
    logic        ready_s [4];
    logic [31:0] data_s  [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic [31:0] sum_s   [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        float_accumulator #(.N(gi + 1)) u_dut (
            .clk      (clk),
            .rst      (rst_s[gi]),
            .start    (start_s[gi]),
            .in_valid (valid_s[gi]),
            .in_ready (ready_s[gi]),
            .in_data  (data_s[gi]),
            .busy     (busy_s[gi]),
            .done     (done_s[gi]),
            .sum      (sum_s[gi])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_acc(input int idx);
        start_s[idx] = 1'b1;
        step();
        start_s[idx] = 1'b0;
        n_checks++;
        if (ready_s[idx] !== 1'b1 || busy_s[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wait[%0d]: ready=%b busy=%b, required ready=1 busy=1", idx, ready_s[idx], busy_s[idx]);
        end
    endtask

    task automatic feed(input int idx, input logic [31:0] v);
        int t = 0;
        valid_s[idx] = 1'b1;
        data_s[idx]  = v;
        while (ready_s[idx] !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        if (ready_s[idx] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout[%0d]: in_ready=%b after %0d cycles, required 1", idx, ready_s[idx], t);
        end
        step();
        valid_s[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input logic [31:0] exp_sum, input string name);
        int t = 0;
        while (done_s[idx] !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        n_checks++;
        if (done_s[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done_s[idx], t);
        end
        n_checks++;
        if (sum_s[idx] !== exp_sum) begin
            n_fail++;
            $display("FAIL %s_sum: got %h, required %h", name, sum_s[idx], exp_sum);
        end
        $display("run %s: N=%0d sum=%h expected=%h", name, idx + 1, sum_s[idx], exp_sum);
        step();
        n_checks++;
        if (done_s[idx] !== 1'b0 || busy_s[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: done=%b busy=%b, required done=0 busy=0", name, done_s[idx], busy_s[idx]);
        end
        step();
        n_checks++;
        if (sum_s[idx] !== exp_sum) begin
            n_fail++;
            $display("FAIL %s_hold: got %h, required %h", name, sum_s[idx], exp_sum);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; valid_s[i] = 1'b0; data_s[i] = '0;
        end
        step(); step();
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ready_s[i] !== 1'b0 || busy_s[i] !== 1'b0 || done_s[i] !== 1'b0 || sum_s[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: ready=%b busy=%b done=%b sum=%h, required 0 0 0 00000000",
                         i, ready_s[i], busy_s[i], done_s[i], sum_s[i]);
            end
        end
    endtask

    task automatic test_sum_1234();
        start_acc(3);
        feed(3, 32'h3F800000);
        feed(3, 32'h40000000);
        feed(3, 32'h40400000);
        feed(3, 32'h40800000);
        wait_done(3, 32'h41200000, "sum_1234");
    endtask

    task automatic test_cancel();
        start_acc(1);
        feed(1, 32'h3FC00000);
        feed(1, 32'hBFC00000);
        wait_done(1, 32'h00000000, "cancel");
    endtask

    task automatic test_clamp();
        start_acc(1);
        feed(1, 32'h3F800000);
        feed(1, 32'h30800000);
        wait_done(1, 32'h3F800000, "clamp");
    endtask

    task automatic test_saturate();
        start_acc(1);
        feed(1, 32'h7F7FFFFF);
        feed(1, 32'h7F7FFFFF);
        wait_done(1, 32'h7F7FFFFF, "sat_pos");
        start_acc(1);
        feed(1, 32'hFF7FFFFF);
        feed(1, 32'hFF7FFFFF);
        wait_done(1, 32'hFF7FFFFF, "sat_neg");
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int since   = 0;
        int t       = 0;
        valid_s[2] = 1'b1;
        data_s[2]  = 32'h40000000;
        start_acc(2);
        while (done_s[2] !== 1'b1 && t < 300) begin
            if (ready_s[2] === 1'b1) begin
                if (accepts > 0) begin
                    n_checks++;
                    if (since < 3) begin
                        n_fail++;
                        $display("FAIL bp_ready_gap: in_ready high %0d cycles after accept, required >= 3", since);
                    end
                end
                accepts++;
                since = 0;
            end else begin
                since++;
            end
            step();
            t++;
        end
        n_checks++;
        if (accepts != 3) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d, required 3", accepts);
        end
        wait_done(2, 32'h40C00000, "backpressure");
        n_checks++;
        if (busy_s[2] !== 1'b0 || ready_s[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle_hold: busy=%b ready=%b with valid held, required 0 0", busy_s[2], ready_s[2]);
        end
        valid_s[2] = 1'b0;
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        start_acc(1);
        feed(1, 32'h3F800000);
        feed(1, 32'h3F800000);
        n_checks++;
        if (ready_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_align_ready: got %b, required 0", ready_s[1]);
        end
        step();          // ADD
        step();          // first NORM cycle
        rst_s[1] = 1'b1;
        step();
        rst_s[1] = 1'b0;
        n_checks++;
        if (ready_s[1] !== 1'b0 || busy_s[1] !== 1'b0 || done_s[1] !== 1'b0 || sum_s[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: ready=%b busy=%b done=%b sum=%h, required 0 0 0 00000000",
                     ready_s[1], busy_s[1], done_s[1], sum_s[1]);
        end
        for (int i = 0; i < 30; i++) begin
            if (done_s[1] === 1'b1) pulses++;
            step();
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, required 0", pulses);
        end
        $display("run abort: reset during NORM, done pulses=%0d", pulses);
        start_acc(1);
        feed(1, 32'h3F800000);
        feed(1, 32'h40000000);
        wait_done(1, 32'h40400000, "after_abort");
        start_acc(0);
        feed(0, 32'h3F800000);
        wait_done(0, 32'h3F800000, "n1_single");
    endtask

    initial begin
        test_reset();
        test_sum_1234();
        test_cancel();
        test_clamp();
        test_saturate();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
